// File: rtl/sk6812_pkg.sv
// Package for the SK6812 receive pixel.
// Holds the FSM state type, the word length, default tick counts (10 MHz
// clock, 100 ns per tick) and the bit offsets of the G/R/B fields inside a
// received 24-bit word.
package sk6812_pkg;

  typedef enum logic [1:0] {
    WAIT_RST,
    RX,
    FWD
  } state_t;

  localparam int unsigned LED_BITS = 24;

  localparam int unsigned T_TH_DEF   = 5;
  localparam int unsigned T_HMAX_DEF = 12;
  localparam int unsigned T_RST_DEF  = 500;
  localparam int unsigned T0H_DEF    = 3;
  localparam int unsigned T1H_DEF    = 6;

  // {G,R,B}, G sent first
  localparam int unsigned G_LSB = 16;
  localparam int unsigned R_LSB = 8;
  localparam int unsigned B_LSB = 0;

endpackage

// File: rtl/sk6812_rx_if.sv
// Pixel-side signal bundle of the SK6812 receiver.
//   din        serial data into the pixel (asynchronous to the clock)
//   dout       serial data forwarded to the next pixel
//   pix_data   last complete {G,R,B} word
//   pix_valid  one-cycle pulse when pix_data updates
//   frame_rst  one-cycle pulse per detected reset gap
//   bit_err    one-cycle pulse on an over-long high pulse
// Modports: slave = the pixel (receiver), master = the line driver/observer.
interface sk6812_rx_if
  import sk6812_pkg::*;
  ();

  logic                din;
  logic                dout;
  logic [LED_BITS-1:0] pix_data;
  logic                pix_valid;
  logic                frame_rst;
  logic                bit_err;

  modport slave (
    input  din,
    output dout,
    output pix_data,
    output pix_valid,
    output frame_rst,
    output bit_err
  );

  modport master (
    output din,
    input  dout,
    input  pix_data,
    input  pix_valid,
    input  frame_rst,
    input  bit_err
  );

endinterface

// File: rtl/sk6812_pulse_meas.sv
// Line measurement for the SK6812 receiver.
// Synchronises din, finds the edges of the synchronised line, measures high
// and low times and turns them into strobes.
//   sys_clk   10 MHz clock
//   sys_nrst  asynchronous active-low reset
//   din       raw serial input
//   din_s     synchronised input
//   bit_stb   one-cycle strobe on each fall of din_s
//   bit_val   decoded bit value (high time >= T_TH); valid with bit_stb,
//             and as a level it tells whether the current high is a code1
//   gap_stb   one-cycle strobe when the low time reaches T_RST
//   err_stb   one-cycle strobe when the high time exceeds T_HMAX
module sk6812_pulse_meas #(
  parameter int unsigned T_TH   = 5,
  parameter int unsigned T_HMAX = 12,
  parameter int unsigned T_RST  = 500
) (
  input  logic sys_clk,
  input  logic sys_nrst,
  input  logic din,
  output logic din_s,
  output logic bit_stb,
  output logic bit_val,
  output logic gap_stb,
  output logic err_stb
);

  localparam int unsigned HW = $clog2(T_HMAX + 2);
  localparam int unsigned LW = $clog2(T_RST + 1);

  localparam logic [HW-1:0] HI_TH   = HW'(T_TH);
  localparam logic [HW-1:0] HI_MAX  = HW'(T_HMAX);
  localparam logic [HW-1:0] HI_SAT  = HW'(T_HMAX + 1);
  localparam logic [LW-1:0] LO_SAT  = LW'(T_RST);
  localparam logic [LW-1:0] LO_LAST = LW'(T_RST - 1);

  logic          din_m;
  logic          din_q;
  logic          rise;
  logic [HW-1:0] hi_cnt;
  logic [LW-1:0] lo_cnt;

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_q <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_q <= din_s;
    end
  end

  assign rise    = din_s & ~din_q;
  assign bit_stb = ~din_s & din_q;
  assign bit_val = (hi_cnt >= HI_TH);

  // hi_cnt equals the number of high cycles seen so far in the current
  // pulse, so at the fall it holds the full pulse width.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      hi_cnt  <= '0;
      lo_cnt  <= '0;
      gap_stb <= 1'b0;
      err_stb <= 1'b0;
    end else begin
      if (rise) begin
        hi_cnt <= HW'(1);
      end else if (din_s && hi_cnt != HI_SAT) begin
        hi_cnt <= hi_cnt + 1'b1;
      end

      if (din_s) begin
        lo_cnt <= '0;
      end else if (lo_cnt != LO_SAT) begin
        lo_cnt <= lo_cnt + 1'b1;
      end

      // Both strobes fire on the step into saturation, so each fires once
      // per pulse/gap no matter how long the line stays put.
      gap_stb <= ~din_s & (lo_cnt == LO_LAST);
      err_stb <= din_s & ~rise & (hi_cnt == HI_MAX);
    end
  end

endmodule

// File: rtl/sk6812_rx.sv
// SK6812 receive pixel.
// Acts as one pixel on the NRZ chain: after a reset gap it decodes the first
// 24 bits into pix_data ({G,R,B}, MSB first) and forwards every later bit on
// dout. dout stays low while waiting for a gap and while the own word is
// being received.
//   sys_clk   10 MHz clock (one tick = 100 ns)
//   sys_nrst  asynchronous active-low reset
//   bus       sk6812_rx_if.slave: din, dout, pix_data, pix_valid,
//             frame_rst, bit_err
// Build option SK6812_RESHAPE_EN: forwarded highs are regenerated as clean
// T0H/T1H pulses instead of being passed through raw.
module sk6812_rx
  import sk6812_pkg::*;
#(
  parameter int unsigned T_TH   = T_TH_DEF,
  parameter int unsigned T_HMAX = T_HMAX_DEF,
  parameter int unsigned T_RST  = T_RST_DEF
`ifdef SK6812_RESHAPE_EN
  ,
  parameter int unsigned T0H    = T0H_DEF,
  parameter int unsigned T1H    = T1H_DEF
`endif
) (
  input  logic        sys_clk,
  input  logic        sys_nrst,
  sk6812_rx_if.slave  bus
);

  localparam logic [4:0] WORD_LEN = 5'(LED_BITS);

  logic din_s;
  logic bit_stb;
  logic bit_val;
  logic gap_stb;
  logic err_stb;

  state_t              state;
  state_t              state_nxt;
  logic [4:0]          bit_cnt;
  logic [LED_BITS-1:0] shreg;
  logic [LED_BITS-1:0] pix_data_q;
  logic                pix_valid_q;
  logic                word_done;
  logic                dout_q;
  logic                dout_nxt;
  logic                fwd_bit;

  sk6812_pulse_meas #(
    .T_TH   (T_TH),
    .T_HMAX (T_HMAX),
    .T_RST  (T_RST)
  ) u_meas (
    .sys_clk  (sys_clk),
    .sys_nrst (sys_nrst),
    .din      (bus.din),
    .din_s    (din_s),
    .bit_stb  (bit_stb),
    .bit_val  (bit_val),
    .gap_stb  (gap_stb),
    .err_stb  (err_stb)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state <= WAIT_RST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_done = 1'b0;
    case (state)
      WAIT_RST: state_nxt = WAIT_RST;
      RX: begin
        // Word commits the cycle after the 24th fall.
        if (bit_cnt == WORD_LEN) begin
          word_done = ~err_stb;
          state_nxt = FWD;
        end
      end
      FWD:      state_nxt = FWD;
      default:  state_nxt = WAIT_RST;
    endcase
    if (gap_stb) begin
      state_nxt = RX;
    end
    if (err_stb) begin
      state_nxt = WAIT_RST;
    end
  end

  // ------------------------------------------------ shift register / word
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      if (gap_stb) begin
        bit_cnt <= '0;
      end else if (state == RX && bit_stb && bit_cnt < WORD_LEN) begin
        shreg   <= {shreg[LED_BITS-2:0], bit_val};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (word_done) begin
        pix_data_q <= shreg;
      end
      pix_valid_q <= word_done;
    end
  end

  // ------------------------------------------------------------ dout path
`ifdef SK6812_RESHAPE_EN
  // The short/long decision is only known once hi_cnt reaches T_TH, so the
  // regenerated pulse starts RS_DLY cycles after the rise; that way a code0
  // can still end exactly T0H cycles after it began.
  localparam logic [7:0] RS_DLY = 8'((T_TH > T0H) ? (T_TH - T0H) : 0);
  localparam logic [7:0] RS_T0  = 8'(T0H);
  localparam logic [7:0] RS_T1  = 8'(T1H);

  logic       rs_din_q;
  logic       rs_rise;
  logic       rs_act;
  logic       rs_long;
  logic       rs_long_now;
  logic       rs_end;
  logic [7:0] rs_cnt;
  logic [7:0] rs_ph;
  logic [7:0] rs_len;

  always_comb begin
    rs_rise     = din_s & ~rs_din_q;
    rs_ph       = rs_rise ? 8'd0 : rs_cnt;
    rs_long_now = ~rs_rise & (rs_long | bit_val);
    rs_len      = rs_long_now ? RS_T1 : RS_T0;
    fwd_bit     = (rs_rise | rs_act) && (rs_ph >= RS_DLY) && (rs_ph < RS_DLY + rs_len);
    rs_end      = rs_act && ~rs_rise && (rs_ph >= RS_DLY + rs_len);
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rs_din_q <= 1'b0;
      rs_act   <= 1'b0;
      rs_long  <= 1'b0;
      rs_cnt   <= '0;
    end else begin
      rs_din_q <= din_s;
      if (rs_rise) begin
        rs_act  <= 1'b1;
        rs_long <= 1'b0;
        rs_cnt  <= 8'd1;
      end else if (rs_act) begin
        rs_long <= rs_long_now;
        if (rs_end) begin
          rs_act <= 1'b0;
        end
        if (rs_cnt != 8'hFF) begin
          rs_cnt <= rs_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign fwd_bit = din_s;
`endif

  always_comb begin
    dout_nxt = 1'b0;
    if (state == FWD && !err_stb) begin
      dout_nxt = fwd_bit;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= dout_nxt;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.frame_rst = gap_stb;
  assign bus.bit_err   = err_stb;

endmodule

// File: tb/tb_sk6812_rx.sv
// Directed bench for sk6812_rx. Inputs change on the falling clock edge,
// outputs are sampled on the falling edge. A monitor counts output pulses
// and decodes forwarded dout pulses; each test task compares deltas of
// those counters and output values against hand-computed expectations.
module tb_sk6812_rx;
  import sk6812_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_nrst;

  sk6812_rx_if bus_if ();

  sk6812_rx dut (
    .sys_clk  (sys_clk),
    .sys_nrst (sys_nrst),
    .bus      (bus_if)
  );

  always #50 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // ------------------------------------------------------------ monitor
  int          pv_cnt     = 0;
  int          fr_cnt     = 0;
  int          err_cnt    = 0;
  int          err_hi     = 0;
  int          dout_rises = 0;
  int          dly_bad    = 0;
  int          w_cur      = 0;
  int          w_last     = 0;
  int          w_prev     = 0;
  logic [23:0] dout_word  = '0;
  logic        dout_q     = 1'b0;
  logic        err_q      = 1'b0;
  logic [7:0]  hist       = '0;
  logic        chk_dly    = 1'b0;

  always @(posedge sys_clk) hist = {hist[6:0], bus_if.din};

  always @(negedge sys_clk) begin
    if (bus_if.pix_valid === 1'b1) pv_cnt++;
    if (bus_if.frame_rst === 1'b1) fr_cnt++;
    if (bus_if.bit_err === 1'b1) begin
      err_hi++;
      if (!err_q) err_cnt++;
    end
    err_q = bus_if.bit_err;
    if (bus_if.dout === 1'b1) begin
      if (!dout_q) dout_rises++;
      w_cur++;
    end else if (dout_q) begin
      dout_word = {dout_word[22:0], (w_cur >= 5)};
      w_prev = w_last;
      w_last = w_cur;
      w_cur  = 0;
    end
    dout_q = bus_if.dout;
    // dout must equal din delayed by three clock edges
    if (chk_dly && bus_if.dout !== hist[2]) dly_bad++;
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic b);
    bus_if.din = 1'b1;
    tick(b ? 6 : 3);
    bus_if.din = 1'b0;
    tick(b ? 6 : 9);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic gap();
    bus_if.din = 1'b0;
    tick(600);
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    sys_nrst   = 1'b1;
    bus_if.din = 1'b0;
    tick(2);
    sys_nrst   = 1'b0;
    bus_if.din = 1'b1;
    tick(3);
    total++; if (bus_if.dout !== 1'b0) begin bad++; $display("FAIL rst_dout: got %b want 0", bus_if.dout); end
    total++; if (bus_if.pix_data !== 24'h0) begin bad++; $display("FAIL rst_pix_data: got %h want 000000", bus_if.pix_data); end
    total++; if (bus_if.pix_valid !== 1'b0) begin bad++; $display("FAIL rst_pix_valid: got %b want 0", bus_if.pix_valid); end
    total++; if (bus_if.frame_rst !== 1'b0) begin bad++; $display("FAIL rst_frame_rst: got %b want 0", bus_if.frame_rst); end
    total++; if (bus_if.bit_err !== 1'b0) begin bad++; $display("FAIL rst_bit_err: got %b want 0", bus_if.bit_err); end
    total++; if (dut.state !== WAIT_RST) begin bad++; $display("FAIL rst_state: got %0d want %0d", dut.state, WAIT_RST); end
  endtask

  task automatic test_powerup();
    int first = -1;
    int fr0, pv0, er0, dr0;
    pv0 = pv_cnt; er0 = err_cnt; dr0 = dout_rises; fr0 = fr_cnt;
    sys_nrst = 1'b1;
    tick(4);
    for (int i = 0; i < 5; i++) begin
      bus_if.din = 1'b0; tick(6);
      bus_if.din = 1'b1; tick(6);
    end
    tick(4);
    bus_if.din = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      tick(1);
      if (bus_if.frame_rst === 1'b1 && first < 0) first = i;
    end
    total++; if (first != 502) begin bad++; $display("FAIL pwr_gap_cycle: got %0d want 502", first); end
    total++; if (fr_cnt - fr0 != 1) begin bad++; $display("FAIL pwr_gap_count: got %0d want 1", fr_cnt - fr0); end
    total++; if (pv_cnt - pv0 != 0) begin bad++; $display("FAIL pwr_pix_valid: got %0d want 0", pv_cnt - pv0); end
    total++; if (err_cnt - er0 != 0) begin bad++; $display("FAIL pwr_bit_err: got %0d want 0", err_cnt - er0); end
    total++; if (dout_rises - dr0 != 0) begin bad++; $display("FAIL pwr_dout: got %0d want 0", dout_rises - dr0); end
  endtask

  task automatic test_word();
    int pv0, dr0, er0;
    gap();
    pv0 = pv_cnt; dr0 = dout_rises; er0 = err_cnt;
    send_word(24'hC0C0C0);
    tick(10);
    total++; if (pv_cnt - pv0 != 1) begin bad++; $display("FAIL word_pix_valid: got %0d want 1", pv_cnt - pv0); end
    total++; if (bus_if.pix_data !== 24'hC0C0C0) begin bad++; $display("FAIL word_pix_data: got %h want c0c0c0", bus_if.pix_data); end
    total++; if (dout_rises - dr0 != 0) begin bad++; $display("FAIL word_dout: got %0d want 0", dout_rises - dr0); end
    total++; if (err_cnt - er0 != 0) begin bad++; $display("FAIL word_bit_err: got %0d want 0", err_cnt - er0); end
  endtask

  task automatic test_forward();
    int pv0, dr0, db0;
    logic [7:0] g;
    gap();
    pv0 = pv_cnt; dr0 = dout_rises; db0 = dly_bad;
    send_word(24'h123456);
    chk_dly = 1'b1;
    send_word(24'hABCDEF);
    tick(20);
    chk_dly = 1'b0;
    g = bus_if.pix_data[G_LSB +: 8];
    total++; if (bus_if.pix_data !== 24'h123456) begin bad++; $display("FAIL fwd_pix_data: got %h want 123456", bus_if.pix_data); end
    total++; if (g !== 8'h12) begin bad++; $display("FAIL fwd_green: got %h want 12", g); end
    total++; if (pv_cnt - pv0 != 1) begin bad++; $display("FAIL fwd_pix_valid: got %0d want 1", pv_cnt - pv0); end
    total++; if (dout_rises - dr0 != 24) begin bad++; $display("FAIL fwd_pulses: got %0d want 24", dout_rises - dr0); end
    total++; if (dout_word !== 24'hABCDEF) begin bad++; $display("FAIL fwd_word: got %h want abcdef", dout_word); end
`ifndef SK6812_RESHAPE_EN
    total++; if (dly_bad - db0 != 0) begin bad++; $display("FAIL fwd_delay3: got %0d want 0 cycle errors", dly_bad - db0); end
`endif
  endtask

  task automatic test_partial();
    int pv0, fr0, er0;
    pv0 = pv_cnt; fr0 = fr_cnt; er0 = err_cnt;
    gap();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    gap();
    total++; if (fr_cnt - fr0 != 2) begin bad++; $display("FAIL part_gaps: got %0d want 2", fr_cnt - fr0); end
    total++; if (pv_cnt - pv0 != 0) begin bad++; $display("FAIL part_pix_valid: got %0d want 0", pv_cnt - pv0); end
    total++; if (bus_if.pix_data !== 24'h123456) begin bad++; $display("FAIL part_pix_data: got %h want 123456", bus_if.pix_data); end
    total++; if (err_cnt - er0 != 0) begin bad++; $display("FAIL part_bit_err: got %0d want 0", err_cnt - er0); end
  endtask

  task automatic test_err();
    int pv0, er0, eh0, dr0;
    gap();
    pv0 = pv_cnt; er0 = err_cnt; eh0 = err_hi; dr0 = dout_rises;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus_if.din = 1'b1; tick(13);
    bus_if.din = 1'b0; tick(6);
    total++; if (dut.state !== WAIT_RST) begin bad++; $display("FAIL err_state: got %0d want %0d", dut.state, WAIT_RST); end
    send_word(24'h00FF00);
    tick(10);
    total++; if (err_cnt - er0 != 1) begin bad++; $display("FAIL err_pulses: got %0d want 1", err_cnt - er0); end
    total++; if (err_hi - eh0 != 1) begin bad++; $display("FAIL err_width: got %0d want 1", err_hi - eh0); end
    total++; if (pv_cnt - pv0 != 0) begin bad++; $display("FAIL err_pix_valid: got %0d want 0", pv_cnt - pv0); end
    total++; if (bus_if.pix_data !== 24'h123456) begin bad++; $display("FAIL err_pix_data: got %h want 123456", bus_if.pix_data); end
    total++; if (dout_rises - dr0 != 0) begin bad++; $display("FAIL err_dout: got %0d want 0", dout_rises - dr0); end
    gap();
    pv0 = pv_cnt;
    send_word(24'h00FF00);
    tick(10);
    total++; if (pv_cnt - pv0 != 1) begin bad++; $display("FAIL err_recover_valid: got %0d want 1", pv_cnt - pv0); end
    total++; if (bus_if.pix_data !== 24'h00FF00) begin bad++; $display("FAIL err_recover_data: got %h want 00ff00", bus_if.pix_data); end
  endtask

  task automatic test_reset_mid();
    int pv0;
    gap();
    for (int i = 0; i < 12; i++) send_bit(i[0]);
    bus_if.din = 1'b1;
    tick(2);
    sys_nrst = 1'b0;
    #1;
    total++; if (bus_if.pix_data !== 24'h0) begin bad++; $display("FAIL mid_pix_data: got %h want 000000", bus_if.pix_data); end
    total++; if (bus_if.dout !== 1'b0) begin bad++; $display("FAIL mid_dout: got %b want 0", bus_if.dout); end
    total++; if (bus_if.pix_valid !== 1'b0) begin bad++; $display("FAIL mid_pix_valid: got %b want 0", bus_if.pix_valid); end
    total++; if (dut.state !== WAIT_RST) begin bad++; $display("FAIL mid_state: got %0d want %0d", dut.state, WAIT_RST); end
    tick(3);
    bus_if.din = 1'b0;
    sys_nrst   = 1'b1;
    pv0 = pv_cnt;
    send_word(24'h5A5AA5);
    tick(10);
    total++; if (pv_cnt - pv0 != 0) begin bad++; $display("FAIL mid_no_gap_valid: got %0d want 0", pv_cnt - pv0); end
    total++; if (bus_if.pix_data !== 24'h0) begin bad++; $display("FAIL mid_no_gap_data: got %h want 000000", bus_if.pix_data); end
    gap();
    pv0 = pv_cnt;
    send_word(24'h5A5AA5);
    tick(10);
    total++; if (pv_cnt - pv0 != 1) begin bad++; $display("FAIL mid_resume_valid: got %0d want 1", pv_cnt - pv0); end
    total++; if (bus_if.pix_data !== 24'h5A5AA5) begin bad++; $display("FAIL mid_resume_data: got %h want 5a5aa5", bus_if.pix_data); end
  endtask

`ifdef SK6812_RESHAPE_EN
  task automatic test_reshape();
    int dr0;
    gap();
    send_word(24'h0F0F0F);
    dr0 = dout_rises;
    bus_if.din = 1'b1; tick(4);
    bus_if.din = 1'b0; tick(10);
    bus_if.din = 1'b1; tick(7);
    bus_if.din = 1'b0; tick(15);
    total++; if (dout_rises - dr0 != 2) begin bad++; $display("FAIL rs_pulses: got %0d want 2", dout_rises - dr0); end
    total++; if (w_prev != 3) begin bad++; $display("FAIL rs_short_width: got %0d want 3", w_prev); end
    total++; if (w_last != 6) begin bad++; $display("FAIL rs_long_width: got %0d want 6", w_last); end
  endtask
`endif

  initial begin
    test_reset();
    test_powerup();
    test_word();
    test_forward();
    test_partial();
    test_err();
    test_reset_mid();
`ifdef SK6812_RESHAPE_EN
    test_reshape();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
